// File: rtl/tmds_ddr_serializer.sv
// +----------------------------------------------------------------------------+
// | Module : tmds_ddr_serializer                                               |
// | Brief  : Buffers 10-bit TMDS R/G/B words and emits them as 2-bit DDR       |
// |          slices, five per word period, with a regenerated clock channel.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tmds_ddr_serializer #(
    parameter logic [9:0] IDLE_WORD  = 10'b1101010100,
    parameter logic [9:0] CLOCK_WORD = 10'b0000011111
) (
    input  logic       clk_shift,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_red,
    input  logic [9:0] in_green,
    input  logic [9:0] in_blue,
    output logic [1:0] out_clock,
    output logic [1:0] out_red,
    output logic [1:0] out_green,
    output logic [1:0] out_blue,
    output logic [2:0] phase,
    output logic       underrun
);

    localparam logic [2:0] c_LOAD_PHASE = 3'd4;
    localparam logic [1:0] c_DEPTH      = 2'd2;

    logic [29:0] r_fifo [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_ready;

    logic [2:0]  r_phase;
    logic [9:0]  r_sh_r;
    logic [9:0]  r_sh_g;
    logic [9:0]  r_sh_b;
    logic [9:0]  r_sh_c;
    logic        r_armed;
    logic        r_underrun;

    logic        w_push;
    logic        w_load;
    logic        w_pop;
    logic [29:0] w_head;
    logic [1:0]  w_count_next;

    assign w_push = in_valid & r_ready;
    assign w_load = (r_phase == c_LOAD_PHASE);
    // Pop decision uses the pre-edge count, so a word pushed on this edge cannot be loaded on it.
    assign w_pop  = w_load & (r_count != 2'd0);
    assign w_head = r_fifo[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk_shift) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {in_red, in_green, in_blue};
        end
    end

    always_ff @(posedge clk_shift) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next < c_DEPTH);
        end
    end

    always_ff @(posedge clk_shift) begin
        if (reset) begin
            r_phase    <= 3'd0;
            r_sh_r     <= IDLE_WORD;
            r_sh_g     <= IDLE_WORD;
            r_sh_b     <= IDLE_WORD;
            r_sh_c     <= CLOCK_WORD;
            r_armed    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_phase <= 3'd0;
                r_sh_c  <= CLOCK_WORD;
                if (w_pop) begin
                    r_sh_r <= w_head[29:20];
                    r_sh_g <= w_head[19:10];
                    r_sh_b <= w_head[9:0];
                end else begin
                    r_sh_r <= IDLE_WORD;
                    r_sh_g <= IDLE_WORD;
                    r_sh_b <= IDLE_WORD;
                    if (r_armed) begin
                        r_underrun <= 1'b1;
                    end
                end
            end else begin
                r_phase <= r_phase + 3'd1;
                r_sh_r  <= {2'b00, r_sh_r[9:2]};
                r_sh_g  <= {2'b00, r_sh_g[9:2]};
                r_sh_b  <= {2'b00, r_sh_b[9:2]};
                r_sh_c  <= {2'b00, r_sh_c[9:2]};
            end
            if (w_push) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign in_ready  = r_ready;
    assign out_red   = r_sh_r[1:0];
    assign out_green = r_sh_g[1:0];
    assign out_blue  = r_sh_b[1:0];
    assign out_clock = r_sh_c[1:0];
    assign phase     = r_phase;
    assign underrun  = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_tmds_ddr_serializer.sv
// +----------------------------------------------------------------------------+
// | Module : tb_tmds_ddr_serializer                                            |
// | Brief  : Directed self-checking bench; a word queue predicts each slice.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tmds_ddr_serializer;

    localparam logic [9:0] c_IDLE  = 10'b1101010100;
    localparam logic [9:0] c_CLOCK = 10'b0000011111;

    logic       clk_shift = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_red;
    logic [9:0] in_green;
    logic [9:0] in_blue;
    logic [1:0] out_clock;
    logic [1:0] out_red;
    logic [1:0] out_green;
    logic [1:0] out_blue;
    logic [2:0] phase;
    logic       underrun;

    always #5 clk_shift = ~clk_shift;

    tmds_ddr_serializer dut (
        .clk_shift (clk_shift),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .out_clock (out_clock),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue),
        .phase     (phase),
        .underrun  (underrun)
    );

    int          total = 0;
    int          bad   = 0;
    logic [29:0] sb [$];
    logic [9:0]  m_r, m_g, m_b, m_c;
    logic [2:0]  m_phase;
    logic        m_ready, m_armed, m_under, m_push;
    logic [1:0]  idle_tab  [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [1:0]  clock_tab [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the expectation at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk_shift);
        m_push = in_valid && m_ready && !reset;
        if (reset) begin
            sb.delete();
            m_phase = 3'd0;
            m_r = c_IDLE; m_g = c_IDLE; m_b = c_IDLE; m_c = c_CLOCK;
            m_ready = 1'b1; m_armed = 1'b0; m_under = 1'b0;
        end else begin
            if (m_phase == 3'd4) begin
                m_phase = 3'd0;
                m_c = c_CLOCK;
                if (sb.size() > 0) begin
                    {m_r, m_g, m_b} = sb.pop_front();
                end else begin
                    m_r = c_IDLE; m_g = c_IDLE; m_b = c_IDLE;
                    if (m_armed) m_under = 1'b1;
                end
            end else begin
                m_phase = m_phase + 3'd1;
                m_r = m_r >> 2; m_g = m_g >> 2; m_b = m_b >> 2; m_c = m_c >> 2;
            end
            if (m_push) begin
                sb.push_back({in_red, in_green, in_blue});
                m_armed = 1'b1;
            end
            m_ready = (sb.size() < 2);
        end
        @(negedge clk_shift);
        chk("phase",     phase,     m_phase);
        chk("in_ready",  in_ready,  m_ready);
        chk("underrun",  underrun,  m_under);
        chk("out_red",   out_red,   m_r[1:0]);
        chk("out_green", out_green, m_g[1:0]);
        chk("out_blue",  out_blue,  m_b[1:0]);
        chk("out_clock", out_clock, m_c[1:0]);
    endtask

    task automatic wait_phase(input logic [2:0] k);
        int n = 0;
        while (m_phase != k && n < 10) begin
            cycle();
            n++;
        end
    endtask

    task automatic set_word(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        in_red = r; in_green = g; in_blue = b;
    endtask

    logic [9:0] w3_r [3] = '{10'h3FF, 10'h155, 10'h0F0};
    logic [9:0] w3_g [3] = '{10'h001, 10'h2AA, 10'h30C};
    logic [9:0] w3_b [3] = '{10'h123, 10'h0C3, 10'h3C0};

    initial begin
        int  idx;
        logic saw_block;
        reset = 1'b1; in_valid = 1'b0; set_word(10'h0, 10'h0, 10'h0);
        m_ready = 1'b1; m_phase = 3'd0;
        cycle(); cycle();
        reset = 1'b0;

        // Idle after reset: fixed slice patterns, no underrun.
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t1_red",   out_red,   idle_tab[m_phase]);
            chk("t1_clock", out_clock, clock_tab[m_phase]);
        end
        chk("t1_underrun", underrun, 1'b0);

        // Single word pushed at phase 1.
        wait_phase(3'd1);
        in_valid = 1'b1; set_word(10'h3FF, 10'h000, 10'h2AA);
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_red",   out_red,   2'b11);
            chk("t2_green", out_green, 2'b00);
            chk("t2_blue",  out_blue,  2'b10);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_idle", out_red, idle_tab[m_phase]);
        end

        // Three words with in_valid held high.
        idx = 0; saw_block = 1'b0;
        in_valid = 1'b1; set_word(w3_r[0], w3_g[0], w3_b[0]);
        for (int i = 0; i < 30 && idx < 3; i++) begin
            cycle();
            if (m_push) idx++;
            if (!in_ready) saw_block = 1'b1;
            if (idx < 3) set_word(w3_r[idx], w3_g[idx], w3_b[idx]);
        end
        in_valid = 1'b0;
        chk("t3_all_accepted", idx, 3);
        chk("t3_ready_dropped", saw_block, 1'b1);
        for (int i = 0; i < 20; i++) cycle();

        // Underrun after a two-word stream, sticky across later pushes.
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("t4_reset_underrun", underrun, 1'b0);
        in_valid = 1'b1; set_word(10'h2AA, 10'h155, 10'h3FF); cycle();
        set_word(10'h00F, 10'h3F0, 10'h0AA); cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        chk("t4_underrun_set", underrun, 1'b1);
        in_valid = 1'b1; set_word(10'h111, 10'h222, 10'h333); cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t4_underrun_sticky", underrun, 1'b1);

        // Reset mid-word with two words queued.
        reset = 1'b1; cycle(); reset = 1'b0;
        in_valid = 1'b1; set_word(10'h3FF, 10'h3FF, 10'h3FF); cycle();
        set_word(10'h2AA, 10'h2AA, 10'h2AA); cycle();
        in_valid = 1'b0;
        wait_phase(3'd2);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("t5_ready",    in_ready,  1'b1);
        chk("t5_phase",    phase,     3'd0);
        chk("t5_red",      out_red,   2'b00);
        chk("t5_clock",    out_clock, 2'b11);
        chk("t5_underrun", underrun,  1'b0);
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("t5_no_stale", out_red, idle_tab[m_phase]);
        end
        chk("t5_underrun_end", underrun, 1'b0);

        // Push at phase 4 with an empty buffer: no bypass into that load.
        wait_phase(3'd4);
        in_valid = 1'b1; set_word(10'h155, 10'h0F0, 10'h3FF);
        cycle();
        in_valid = 1'b0;
        chk("t6_idle_slice", out_red,  2'b00);
        chk("t6_underrun",   underrun, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_word_red", out_red, 2'b01);
        end
        chk("t6_underrun_before", underrun, 1'b0);
        cycle();
        chk("t6_underrun_after", underrun, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
